rr_onehot_arbiter: RTL and testbench

//   Round-robin arbiter sitting directly upstream of the 8-to-3 encoder.

---
 rtl/rr_onehot_arbiter.sv | 67 ++++++
 tb/tb_rr_onehot_arbiter.sv | 119 +++++++++++
 2 files changed

// File: rtl/rr_onehot_arbiter.sv
// rr_onehot_arbiter: round-robin arbiter with locked one-hot grant, release and hold timeout
module rr_onehot_arbiter #(
  parameter int N = 8,
  parameter int MAX_HOLD = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         release_i,
  output logic [N-1:0] grant,
  output logic         grant_valid,
  output logic         timeout
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int HW = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] LAST = HW'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;
  logic [0:0] state;
  logic [PW-1:0] ptr, owner, win, idx, nxt_ptr;
  logic [HW-1:0] hold_cnt;
  logic found, expire;
  always_comb begin
    win = '0;
    idx = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      idx = PW'((32'(ptr) + i) % N);
      if (!found && req[idx]) begin
        win = idx;
        found = 1'b1;
      end
    end
  end
  assign nxt_ptr = (32'(owner) == N - 1) ? '0 : owner + 1'b1;
  assign expire = (MAX_HOLD > 0) && (hold_cnt == LAST);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      grant <= '0;
      grant_valid <= 1'b0;
      timeout <= 1'b0;
      ptr <= '0;
      owner <= '0;
      hold_cnt <= '0;
    end else begin
      timeout <= 1'b0;
      if (state == IDLE) begin
        if (found) begin
          state <= GRANT;
          grant <= {{(N-1){1'b0}}, 1'b1} << win;
          grant_valid <= 1'b1;
          owner <= win;
          hold_cnt <= '0;
        end
      end else if (release_i || expire) begin
        state <= IDLE;
        grant <= '0;
        grant_valid <= 1'b0;
        ptr <= nxt_ptr;
        timeout <= !release_i;
      end else if (hold_cnt != '1) begin
        hold_cnt <= hold_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// tb_rr_onehot_arbiter: table-driven scoreboard bench for rr_onehot_arbiter
module tb_rr_onehot_arbiter;
  typedef struct {
    logic [7:0] req;
    logic rel;
    logic [7:0] grant;
    logic to;
  } vec_t;
  typedef struct {
    logic [7:0] grant;
    logic to;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [7:0] req = '0;
  logic release_i = 1'b0;
  logic [7:0] grant;
  logic grant_valid, timeout;
  int checks = 0;
  int errors = 0;
  vec_t tbl[$];
  exp_t sb[$];
  rr_onehot_arbiter #(.N(8), .MAX_HOLD(16)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req(req),
    .release_i(release_i),
    .grant(grant),
    .grant_valid(grant_valid),
    .timeout(timeout)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (!$onehot0(grant) || grant_valid !== |grant) begin
        errors++;
        $display("FAIL onehot/valid: grant=%b valid=%b", grant, grant_valid);
      end
    end
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic cyc(input logic [7:0] r, input logic rl, input logic [7:0] eg, input logic et, input string nm);
    exp_t e;
    req = r;
    release_i = rl;
    sb.push_back('{eg, et});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({nm, " grant"}, 32'(grant), 32'(e.grant));
    chk({nm, " valid"}, 32'(grant_valid), 32'(|e.grant));
    chk({nm, " timeout"}, 32'(timeout), 32'(e.to));
  endtask
  task automatic rst_pulse();
    req = '0;
    release_i = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask
  initial begin
    for (int k = 0; k < 9; k++) begin
      tbl.push_back('{(k == 8) ? 8'h81 : 8'hFF, 1'b0, 8'(1 << (k % 8)), 1'b0});
      tbl.push_back('{8'hFF, 1'b1, 8'h00, 1'b0});
    end
    tbl.push_back('{8'h81, 1'b0, 8'h80, 1'b0});
    tbl.push_back('{8'h00, 1'b1, 8'h00, 1'b0});
    tbl.push_back('{8'h00, 1'b1, 8'h00, 1'b0});
    tbl.push_back('{8'h40, 1'b0, 8'h40, 1'b0});
    tbl.push_back('{8'h00, 1'b0, 8'h40, 1'b0});
    tbl.push_back('{8'h00, 1'b1, 8'h00, 1'b0});
    tbl.push_back('{8'h81, 1'b0, 8'h80, 1'b0});
    tbl.push_back('{8'h00, 1'b1, 8'h00, 1'b0});
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset grant", 32'(grant), 32'h0);
    chk("reset valid", 32'(grant_valid), 32'h0);
    chk("reset timeout", 32'(timeout), 32'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) cyc(8'h00, 1'b0, 8'h00, 1'b0, "idle");
    cyc(8'h04, 1'b0, 8'h04, 1'b0, "single");
    for (int i = 0; i < 3; i++) cyc(8'h00, 1'b0, 8'h04, 1'b0, "single hold");
    cyc(8'h00, 1'b1, 8'h00, 1'b0, "single release");
    rst_pulse();
    for (int i = 0; i < tbl.size(); i++)
      cyc(tbl[i].req, tbl[i].rel, tbl[i].grant, tbl[i].to, $sformatf("vec%0d", i));
    rst_pulse();
    cyc(8'h08, 1'b0, 8'h08, 1'b0, "to start");
    for (int i = 0; i < 15; i++) cyc(8'h08, 1'b0, 8'h08, 1'b0, "to hold");
    cyc(8'h08, 1'b0, 8'h00, 1'b1, "to pulse");
    cyc(8'h18, 1'b0, 8'h10, 1'b0, "to next ptr");
    for (int i = 0; i < 15; i++) cyc(8'h18, 1'b0, 8'h10, 1'b0, "rel+to hold");
    cyc(8'h18, 1'b1, 8'h00, 1'b0, "rel+to same");
    cyc(8'h18, 1'b0, 8'h08, 1'b0, "after rel+to");
    rst_pulse();
    cyc(8'h20, 1'b0, 8'h20, 1'b0, "async grant");
    cyc(8'h20, 1'b0, 8'h20, 1'b0, "async hold");
    #2 rst_n = 1'b0;
    #1;
    chk("async grant", 32'(grant), 32'h0);
    chk("async valid", 32'(grant_valid), 32'h0);
    chk("async timeout", 32'(timeout), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(8'hFF, 1'b0, 8'h01, 1'b0, "post reset");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
